pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/sat_counter.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states, parameter
// defaults and the forwarding-select encodings used by the datapath.
package hazard_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam int CNT_W_DEF          = 16;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that saturates at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) count_d = count_q + W'(1);
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: load-use stalls, branch flushes, memory-wait stalls with a
// sticky timeout, and saturating performance counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             MemReadE,
  input  logic             PCSrcE,
  input  logic             MemBusyM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] LuStallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] MemWaitCnt
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic               init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;
  logic               lu_inc, flush_inc, wait_inc;
  logic               load_use;

  assign load_use = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushW     = 1'b0;
    lu_inc     = 1'b0;
    flush_inc  = 1'b0;
    wait_inc   = 1'b0;

    if (rst) begin
      // Pipeline is held empty while reset is asserted, independent of state.
      StallF = 1'b1;
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          StallF     = 1'b1;
          FlushD     = 1'b1;
          FlushE     = 1'b1;
          FlushW     = 1'b1;
          init_cnt_d = 1'b1;
          if (init_cnt_q) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (MemBusyM) begin
            {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
            state_d = ST_MEM_WAIT;
          end else if (PCSrcE) begin
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            flush_inc = 1'b1;
          end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
            lu_inc = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (MemReadyM) begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
          end else begin
            {StallF, StallD, StallE, StallM, FlushW} = 5'b11111;
            wait_inc = 1'b1;
            if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_d == WAIT_MAX) timeout_d = 1'b1;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= 1'b0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign MemTimeout = timeout_q;

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk(clk), .rst(rst), .inc(lu_inc), .count(LuStallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(flush_inc), .count(FlushCnt)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk(clk), .rst(rst), .inc(wait_inc), .count(MemWaitCnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with a small timeout and narrow
// counters so saturation and timeout are reachable in a few cycles.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 2;

  // Output vector order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_INIT = 7'b1000111;
  localparam logic [6:0] O_LU   = 7'b1100010;
  localparam logic [6:0] O_BR   = 7'b0000110;
  localparam logic [6:0] O_MEM  = 7'b1111001;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1_d, rs2_d, rd_e;
  logic          mem_read_e, pc_src_e, mem_busy_m, mem_ready_m;
  logic          stall_f, stall_d, stall_e, stall_m;
  logic          flush_d, flush_e, flush_w;
  logic          mem_timeout;
  logic [CW-1:0] lu_cnt, fl_cnt, mw_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(rs1_d), .Rs2D(rs2_d), .RdE(rd_e),
    .MemReadE(mem_read_e), .PCSrcE(pc_src_e),
    .MemBusyM(mem_busy_m), .MemReadyM(mem_ready_m),
    .StallF(stall_f), .StallD(stall_d), .StallE(stall_e), .StallM(stall_m),
    .FlushD(flush_d), .FlushE(flush_e), .FlushW(flush_w),
    .MemTimeout(mem_timeout),
    .LuStallCnt(lu_cnt), .FlushCnt(fl_cnt), .MemWaitCnt(mw_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge, push the expected output
  // vector, then pop and compare at the falling edge.
  task automatic step(input string tag, input logic r,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic mr, input logic pc, input logic busy, input logic ready,
                      input logic [6:0] exp_outs);
    logic [6:0] exp_v;
    rst = r; rs1_d = rs1; rs2_d = rs2; rd_e = rd;
    mem_read_e = mr; pc_src_e = pc; mem_busy_m = busy; mem_ready_m = ready;
    exp_q.push_back(exp_outs);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    check(tag, 32'({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}), 32'(exp_v));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic [6:0] exp_outs);
    step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp_outs);
  endtask

  // Reset for one cycle, then the two INIT cycles; leaves the FSM in RUN.
  task automatic do_reset();
    step("rst_outs", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_INIT);
    idle("init1", O_INIT);
    idle("init2", O_INIT);
  endtask

  initial begin
    rst = 1'b1;
    rs1_d = '0; rs2_d = '0; rd_e = '0;
    mem_read_e = 0; pc_src_e = 0; mem_busy_m = 0; mem_ready_m = 0;
    @(posedge clk);
    #1;

    // Reset release and idle RUN
    do_reset();
    check("rst_lu_cnt", 32'(lu_cnt), 0);
    check("rst_timeout", 32'(mem_timeout), 0);
    idle("run_idle", O_NONE);
    step("ready_ignored", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_NONE);

    // Load-use on Rs2D, then RdE=0 must not stall
    step("lu_rs2", 1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU);
    check("lu_cnt_1", 32'(lu_cnt), 1);
    step("lu_rd0", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_NONE);
    check("lu_cnt_still_1", 32'(lu_cnt), 1);
    step("lu_rs1", 1'b0, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, O_LU);
    step("no_load", 1'b0, 5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE);

    // Branch takes priority over load-use
    do_reset();
    step("br_over_lu", 1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_BR);
    check("br_fl_cnt", 32'(fl_cnt), 1);
    check("br_lu_cnt", 32'(lu_cnt), 0);

    // Memory wait with branch held in Execute
    do_reset();
    step("busy", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, O_MEM);
    for (int i = 0; i < 3; i++)
      step("wait", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_MEM);
    check("mw_cnt_3", 32'(mw_cnt), 3);
    check("fl_cnt_0", 32'(fl_cnt), 0);
    step("ready", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, O_NONE);
    step("br_after_wait", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, O_BR);
    check("fl_cnt_1", 32'(fl_cnt), 1);
    check("no_timeout_3", 32'(mem_timeout), 0);

    // Timeout: rises after the 4th wait cycle, sticky, cleared by reset
    do_reset();
    step("to_busy", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_MEM);
    for (int i = 0; i < 3; i++) idle("to_wait", O_MEM);
    check("to_before", 32'(mem_timeout), 0);
    idle("to_wait4", O_MEM);
    check("to_set", 32'(mem_timeout), 1);
    idle("to_still_wait", O_MEM);
    check("to_mw_sat", 32'(mw_cnt), 3);
    step("to_ready", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_NONE);
    check("to_sticky", 32'(mem_timeout), 1);
    do_reset();
    check("to_cleared", 32'(mem_timeout), 0);

    // Reset mid-wait abandons the wait and clears the wait counter
    step("mid_busy", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_MEM);
    idle("mid_wait1", O_MEM);
    idle("mid_wait2", O_MEM);
    do_reset();
    check("mid_mw_cnt", 32'(mw_cnt), 0);
    step("mid_busy2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_MEM);
    for (int i = 0; i < 3; i++) idle("mid_rewait", O_MEM);
    check("mid_no_timeout", 32'(mem_timeout), 0);

    // Counter saturation with 5 load-use events
    do_reset();
    for (int i = 0; i < 5; i++)
      step("sat_lu", 1'b0, 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, O_LU);
    check("lu_sat", 32'(lu_cnt), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
